// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO drain-side stream adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2
  } rd_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // Width of a counter spanning 0..burst_len-1; never narrower than one bit.
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry word buffer between the FIFO read port and the stream output.
// The head entry is a register, so the output word is glitch-free and holds under backpressure.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [BUF_CNT_W-1:0] count,
  output logic [WORD_SIZE-1:0] head_data
);

  logic [WORD_SIZE-1:0] tail_data;

  // NOTE: only two data entries, so clearing them on reset is cheap and keeps m_data at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      // NOTE: non-blocking assignments let head/tail shift and refill in one edge without ordering hazards.
      case ({push, pop})
        2'b10: begin
          if (count == '0) head_data <= push_data;
          else             tail_data <= push_data;
          count <= count + 1'b1;
        end
        2'b01: begin
          head_data <= tail_data;
          count     <= count - 1'b1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, order preserved.
          if (count == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO (registered read data, one-cycle-stale empty) into a valid/ready stream.
// Define FIFO_RD_LAST_EN to enable the burst beat counter driving m_last; otherwise m_last is tied 0.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_enb,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  if (BURST_LEN < 1) begin : g_burst_len_check
    $error("fifo_rd_stream: BURST_LEN must be >= 1");
  end

  rd_state_t            state, state_nxt;
  logic [BUF_CNT_W-1:0] buf_count;
  logic [BUF_CNT_W-1:0] occ_after;
  logic                 out_fire;
  logic                 pop_cond;

  assign m_valid   = (buf_count != '0);
  assign out_fire  = m_valid && m_ready;
  assign occ_after = buf_count - {{(BUF_CNT_W-1){1'b0}}, out_fire};
  // POP is the stale-empty cycle after a pop, so no new pop may be issued from it.
  assign pop_cond  = !fifo_empty && (state != POP) && (occ_after <= 2'd1);
  assign busy      = (state != IDLE) || m_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    fifo_rd_enb = 1'b0;
    case (state)
      IDLE: begin
        if (pop_cond) begin
          fifo_rd_enb = 1'b1;
          state_nxt   = POP;
        end
      end
      POP: state_nxt = CAPTURE;
      CAPTURE: begin
        if (pop_cond) begin
          fifo_rd_enb = 1'b1;
          state_nxt   = POP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // fifo_data is valid during POP and lands in the buffer on the edge into CAPTURE.
  fifo_rd_skid #(
    .WORD_SIZE(WORD_SIZE)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (state == POP),
    .push_data (fifo_data),
    .pop       (out_fire),
    .count     (buf_count),
    .head_data (m_data)
  );

`ifdef FIFO_RD_LAST_EN
  localparam int BEAT_W = beat_cnt_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
    end else if (out_fire) begin
      beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m_last = m_valid && (beat_cnt == BEAT_LAST);
`else
  assign m_last = 1'b0;
`endif

endmodule
